rocket_serial_readout: RTL and testbench
========================================

ROCKET_SERIAL_READOUT -- requirements
Module: rocket_serial_readout

Interface
REQ-001 Parameter WORD_W, default 10, bits per telemetry word (1..16) SHALL be supported.
REQ-002 Parameter N_WORDS, default 52, words per frame (2..64) SHALL be supported.
REQ-003 Parameter IDX_W, default 6, word-index width; SHALL satisfy 2^IDX_W >= N_WORDS.
REQ-004 Parameter MSB_FIRST, default 1, bit order: 1 = MSB first, 0 = LSB first.
REQ-005 clk50  in  1  system clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  level; when high, the rocket is allowed to pull data.
REQ-008 clr  in  1  synchronous frame clear, level-sensitive.
REQ-009 words_in  in  N_WORDS*WORD_W  flat word array; word k occupies bits [k*WORD_W +: WORD_W].
REQ-010 gtclk  in  1  asynchronous rocket gate clock; bits shift on its rising edge.
REQ-011 invload  in  1  asynchronous rocket load, active-low.
REQ-012 ser_data  out  1  serial telemetry bit.
REQ-013 word_idx  out  IDX_W  index of the next word to load.
REQ-014 frame_done  out  1  single-cycle pulse at frame wrap.

Function
REQ-015 gtclk and invload SHALL each pass through a 2-flop synchronizer; invload synchronizer flops SHALL reset to 1, gtclk flops to 0.
REQ-016 Edge detection SHALL compare the synchronized signal with a one-cycle-delayed copy; each detected edge SHALL act exactly once.
REQ-017 Latency: the effect of a raw input edge SHALL appear on outputs at the 3rd clk50 rising edge after the raw edge is first sampled.
REQ-018 Load: on an invload falling edge with enable=1, the WORD_W shift register SHALL capture words_in word word_idx.
REQ-019 After a load, ser_data SHALL present bit WORD_W-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0).
REQ-020 Shift: on a gtclk rising edge with enable=1 and invload synchronized low, the register SHALL shift one position toward the output end, filling with 0.
REQ-021 After WORD_W shifts, ser_data SHALL be 0 until the next load.
REQ-022 gtclk edges while invload is synchronized high SHALL be ignored.
REQ-023 Word advance: on an invload rising edge with enable=1, word_idx SHALL increment by 1.
REQ-024 Wrap: an invload rising edge with word_idx = N_WORDS-1 SHALL set word_idx to 0 and assert frame_done high for exactly one cycle.
REQ-025 enable=0: loads, shifts and word advances SHALL be ignored; ser_data SHALL be forced to 0; word_idx SHALL hold.
REQ-026 clr=1: word_idx and the shift register SHALL go to 0 on the next clock; frame_done SHALL remain 0.
REQ-027 clr SHALL take priority over a simultaneous load, shift or advance.
REQ-028 words_in SHALL be sampled only at load; later changes SHALL NOT affect the bits already in the shift register.
REQ-029 A load coinciding with a gtclk edge SHALL perform the load only.

Reset
REQ-030 While rst=1: ser_data=0, word_idx=0, frame_done=0, shift register=0, synchronizer and edge state at their REQ-015 values.
REQ-031 Deassertion of rst mid-frame SHALL restart the frame at word 0; no spurious edge SHALL be detected on the first cycle after reset.

Verification
REQ-032 Defaults, enable=1, word0=10'h2A5; invload low, 10 gtclk pulses -> ser_data sequence 1,0,1,0,1,0,0,1,0,1, then 0.
REQ-033 52 load/shift/release cycles -> word_idx runs 0..51; frame_done pulses once on the 52nd invload rise; word_idx returns to 0.
REQ-034 MSB_FIRST=0, WORD_W=12, word0=12'h001 -> first bit 1, remaining 11 bits 0.
REQ-035 enable=0 during a full word transaction -> ser_data stays 0, word_idx unchanged; re-enable -> next load uses the same index.
REQ-036 clr at word_idx=17, coincident with an invload rise -> word_idx=0 next cycle, no increment, no frame_done.
REQ-037 Async rst pulse mid-word at word_idx=5 -> all outputs 0 immediately; the next transaction loads word 0.

Source files
------------

// File: rtl/rocket_serial_readout.sv
// rocket_serial_readout: telemetry words shifted out serially under control of the rocket's gate clock and load strobe
module rocket_serial_readout #(
  parameter int WORD_W = 10,
  parameter int N_WORDS = 52,
  parameter int IDX_W = 6,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk50,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clr,
  input  logic [N_WORDS*WORD_W-1:0] words_in,
  input  logic                      gtclk,
  input  logic                      invload,
  output logic                      ser_data,
  output logic [IDX_W-1:0]          word_idx,
  output logic                      frame_done
);
  logic [1:0] gt_sync, il_sync;
  logic gt_d, il_d, load, shift, adv, wrap;
  logic [WORD_W-1:0] sr;
  // two-flop synchronizers plus a delayed copy of each for edge detection; invload idles high
  always_ff @(posedge clk50 or posedge rst)
    if (rst) begin
      gt_sync <= 2'b00;
      gt_d <= 1'b0;
      il_sync <= 2'b11;
      il_d <= 1'b1;
    end else begin
      gt_sync <= {gt_sync[0], gtclk};
      gt_d <= gt_sync[1];
      il_sync <= {il_sync[0], invload};
      il_d <= il_sync[1];
    end
  // qualified rocket events; a load wins over a coincident gate-clock edge
  always_comb begin
    load = enable & il_d & ~il_sync[1];
    adv = enable & ~il_d & il_sync[1];
    shift = enable & gt_sync[1] & ~gt_d & ~il_sync[1] & ~load;
    wrap = word_idx == IDX_W'(N_WORDS - 1);
    ser_data = enable & (MSB_FIRST != 0 ? sr[WORD_W-1] : sr[0]);
  end
  // shift register: capture the indexed word on load, shift toward the output end with zero fill
  always_ff @(posedge clk50 or posedge rst)
    if (rst) sr <= '0;
    else if (clr) sr <= '0;
    else if (load) sr <= words_in[word_idx*WORD_W +: WORD_W];
    else if (shift) sr <= MSB_FIRST != 0 ? sr << 1 : sr >> 1;
  // word index advances on each load release and wraps at the frame end with a one-cycle pulse
  always_ff @(posedge clk50 or posedge rst)
    if (rst) begin
      word_idx <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ~clr & adv & wrap;
      if (clr) word_idx <= '0;
      else if (adv) word_idx <= wrap ? '0 : word_idx + IDX_W'(1);
    end
endmodule

// File: tb/tb_rocket_serial_readout.sv
// tb_rocket_serial_readout: randomized rocket transactions checked against an event-level frame model
module tb_rocket_serial_readout;
  localparam int W = 10;
  localparam int N = 52;
  typedef struct {int due; int kind;} ev_t;
  logic clk50 = 0, rst = 1, enable = 1, clr = 0, gtclk = 0, invload = 1;
  logic [N*W-1:0] words_in = '0;
  logic [47:0] words2 = 48'h001;
  logic ser_data, frame_done, ser2, fd2;
  logic [5:0] word_idx;
  logic [1:0] idx2;
  int checks = 0, errors = 0, cyc = 0, fd_cnt = 0, saved = 0;
  logic en_p = 0, clr_p = 0;
  logic [N*W-1:0] w_p = '0;
  ev_t q[$];
  bit bits[$];
  int m_idx = 0;
  bit m_fd = 0, m_il = 1;
  logic [10:0] exp_s = 11'b10101001010;
  logic [9:0] w0;
  always #10 clk50 = ~clk50;
  rocket_serial_readout dut (
    .clk50(clk50), .rst(rst), .enable(enable), .clr(clr), .words_in(words_in),
    .gtclk(gtclk), .invload(invload), .ser_data(ser_data), .word_idx(word_idx), .frame_done(frame_done)
  );
  rocket_serial_readout #(.WORD_W(12), .N_WORDS(4), .IDX_W(2), .MSB_FIRST(0)) dut2 (
    .clk50(clk50), .rst(rst), .enable(enable), .clr(clr), .words_in(words2),
    .gtclk(gtclk), .invload(invload), .ser_data(ser2), .word_idx(idx2), .frame_done(fd2)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk50);
      #1;
    end
  endtask
  function automatic int gap();
    return $urandom_range(3, 1);
  endfunction
  task automatic rand_words();
    for (int k = 0; k < N; k++) words_in[k*W +: W] = W'($urandom);
  endtask
  // a raw edge first sampled at the next clock takes effect at the third clock
  task automatic set_gt(logic v);
    if (v && !gtclk) q.push_back(ev_t'{cyc + 3, 0});
    gtclk = v;
  endtask
  task automatic set_il(logic v);
    if (v !== invload) q.push_back(ev_t'{cyc + 3, v ? 2 : 1});
    invload = v;
  endtask
  task automatic do_reset();
    rst = 1;
    q.delete();
    bits.delete();
    m_idx = 0;
    m_fd = 0;
    m_il = 1;
    #1;
    chk("rst_ser", ser_data, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_fd", frame_done, 0);
    tick(2);
    rst = 0;
    if (!invload) q.push_back(ev_t'{cyc + 3, 1});
    if (gtclk) q.push_back(ev_t'{cyc + 3, 0});
  endtask
  task automatic xact(int nb, bit co);
    set_il(0);
    if (co) set_gt(1);
    tick(gap());
    if (co) begin
      set_gt(0);
      tick(gap());
    end
    repeat (nb) begin
      if ($urandom_range(3, 0) == 0) rand_words();
      set_gt(1);
      tick(gap());
      set_gt(0);
      tick(gap());
    end
    set_il(1);
    tick(gap());
  endtask
  task automatic pulse();
    set_gt(1);
    tick(2);
    set_gt(0);
    tick(2);
  endtask
  // sample the synchronous inputs exactly as the DUT sees them at each rising edge
  initial forever begin
    @(posedge clk50);
    cyc = cyc + 1;
    en_p = enable;
    clr_p = clr;
    w_p = words_in;
  end
  // frame model: apply rocket events that matured this cycle, then compare every output
  initial forever begin
    bit ld, rs, gr;
    ev_t e;
    @(negedge clk50);
    if (!rst) begin
      m_fd = 0;
      ld = 0;
      rs = 0;
      gr = 0;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.kind == 0) gr = 1;
        else if (e.kind == 1) begin
          ld = 1;
          m_il = 0;
        end else begin
          rs = 1;
          m_il = 1;
        end
      end
      if (clr_p) begin
        bits.delete();
        m_idx = 0;
      end else if (en_p) begin
        if (ld) begin
          bits.delete();
          for (int b = W - 1; b >= 0; b--) bits.push_back(w_p[m_idx*W + b]);
        end else if (gr && !m_il && bits.size() > 0) void'(bits.pop_front());
        if (rs) begin
          m_fd = m_idx == N - 1;
          m_idx = m_fd ? 0 : m_idx + 1;
        end
      end
      chk("ser_data", ser_data, (enable && bits.size() > 0) ? bits[0] : 0);
      chk("word_idx", word_idx, m_idx);
      chk("frame_done", frame_done, m_fd);
      if (frame_done === 1'b1) fd_cnt++;
    end
  end
  initial begin
    rand_words();
    words_in[9:0] = 10'h2A5;
    tick(1);
    do_reset();
    tick(2);
    set_il(0);
    tick(4);
    chk("seq_load", ser_data, exp_s[10]);
    for (int i = 1; i <= 10; i++) begin
      pulse();
      chk($sformatf("seq_bit%0d", i), ser_data, exp_s[10-i]);
    end
    pulse();
    chk("seq_tail", ser_data, 0);
    set_il(1);
    tick(4);
    chk("idx_after_w0", word_idx, 1);
    fd_cnt = 0;
    repeat (50) xact($urandom_range(10, 0), $urandom_range(3, 0) == 0);
    tick(4);
    chk("idx_51", word_idx, 51);
    chk("no_early_fd", fd_cnt, 0);
    xact(3, 0);
    tick(4);
    chk("wrap_idx", word_idx, 0);
    chk("wrap_fd_once", fd_cnt, 1);
    repeat (3) xact(2, 0);
    tick(4);
    saved = word_idx;
    enable = 0;
    tick(1);
    xact(10, 0);
    tick(4);
    chk("dis_idx_hold", word_idx, saved);
    enable = 1;
    tick(1);
    xact(10, 0);
    tick(4);
    chk("reen_idx", word_idx, saved + 1);
    do_reset();
    repeat (17) xact(1, 0);
    tick(4);
    chk("idx_17", word_idx, 17);
    fd_cnt = 0;
    set_il(0);
    tick(2);
    repeat (3) pulse();
    set_il(1);
    tick(2);
    clr = 1;
    tick(1);
    clr = 0;
    tick(3);
    chk("clr_idx", word_idx, 0);
    chk("clr_no_fd", fd_cnt, 0);
    do_reset();
    repeat (5) xact(2, 0);
    tick(4);
    chk("idx_5", word_idx, 5);
    set_il(0);
    tick(2);
    repeat (3) pulse();
    do_reset();
    w0 = words_in[9:0];
    tick(4);
    chk("post_rst_load", ser_data, w0[9]);
    pulse();
    chk("post_rst_bit8", ser_data, w0[8]);
    set_il(1);
    tick(4);
    chk("post_rst_idx", word_idx, 1);
    do_reset();
    tick(2);
    set_il(0);
    tick(4);
    chk("lsb_first", ser2, 1);
    for (int i = 1; i <= 12; i++) begin
      pulse();
      chk($sformatf("lsb_bit%0d", i), ser2, 0);
    end
    set_il(1);
    tick(4);
    repeat (200) begin
      case ($urandom_range(9, 0))
        0: begin
          enable = ~enable;
          tick(gap());
        end
        1: begin
          clr = 1;
          tick(gap());
          clr = 0;
          tick(gap());
        end
        2: pulse();
        3: rand_words();
        default: xact($urandom_range(12, 0), $urandom_range(3, 0) == 0);
      endcase
    end
    enable = 1;
    tick(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
